// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size encodings, FSM states and lane/extension helpers for dmem_arbiter
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  // Size 2'b11 is treated as a word.
  function automatic logic [3:0] mask_from_size(input logic [1:0] size);
    case (size)
      SIZE_B:  return 4'b0001;
      SIZE_H:  return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [1:0] size, input logic uns,
                                              input logic [31:0] data);
    case (size)
      SIZE_B:  return uns ? {24'h0, data[7:0]} : {{24{data[7]}}, data[7:0]};
      SIZE_H:  return uns ? {16'h0, data[15:0]} : {{16{data[15]}}, data[15:0]};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/dmem_rr_arbiter.sv
// rtl/dmem_rr_arbiter.sv - one-hot grant logic; round-robin when DMEM_ARB_ROUND_ROBIN_EN is defined, else fixed priority
module dmem_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PW      = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  input  logic [PW-1:0]      i_last_grant,
  output logic [NUM_REQ-1:0] o_grant
);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic [PW-1:0] w_idx;
  logic          w_found;

  // Search begins one past the last winner so every port gets a turn.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = PW'((int'(i_last_grant) + i) % NUM_REQ);
      if (i_en && !w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = ^i_last_grant;

  // Walk from the top down so the lowest requesting index wins.
  always_comb begin
    o_grant = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_en && i_req[i]) o_grant = NUM_REQ'(1) << i;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data memory arbiter (IDLE/ACCESS/RESP); DMEM_ARB_ROUND_ROBIN_EN selects round-robin
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ-1:0][1:0]        req_size,
  input  logic [NUM_REQ-1:0]             req_unsigned,
  input  logic [NUM_REQ-1:0][31:0]       req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [31:0]                    rsp_rdata,
  output logic [31:0]                    mem_address,
  output logic [31:0]                    mem_write_data,
  output logic                           mem_write_enable,
  output logic [3:0]                     mem_write_mask,
  input  logic [31:0]                    mem_read_data
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t              r_state;
  state_t              w_next_state;
  logic [NUM_REQ-1:0]  w_grant;
  logic [PW-1:0]       w_grant_idx;
  logic                w_accept;
  logic [PW-1:0]       r_port;
  logic [PW-1:0]       r_last_grant;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;

  dmem_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_arb (
    .i_req        (req_valid),
    .i_en         (r_state == IDLE),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  always_comb begin
    w_grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_grant_idx = PW'(i);
    end
  end

  assign w_accept = |w_grant;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = ACCESS;
      ACCESS:  w_next_state = RESP;
      RESP:    if (rsp_ready[r_port]) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready        = '0;
    rsp_valid        = '0;
    mem_write_enable = 1'b0;
    mem_write_mask   = 4'b0000;
    case (r_state)
      IDLE:    req_ready = w_grant;
      ACCESS: begin
        mem_write_enable = r_we;
        mem_write_mask   = mask_from_size(r_size);
      end
      RESP:    rsp_valid[r_port] = 1'b1;
      default: ;
    endcase
  end

  // A write still commits if reset lands in ACCESS: the enable is combinational and the memory samples the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_port       <= '0;
      r_last_grant <= '0;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_size       <= SIZE_B;
      r_unsigned   <= 1'b0;
      r_wdata      <= '0;
      r_rdata      <= '0;
    end else begin
      if (w_accept) begin
        r_port       <= w_grant_idx;
        r_last_grant <= w_grant_idx;
        r_addr       <= req_addr[w_grant_idx];
        r_we         <= req_we[w_grant_idx];
        r_size       <= req_size[w_grant_idx];
        r_unsigned   <= req_unsigned[w_grant_idx];
        r_wdata      <= req_wdata[w_grant_idx];
      end
      if (r_state == ACCESS) begin
        r_rdata <= r_we ? 32'h0 : extend_load(r_size, r_unsigned, mem_read_data);
      end
    end
  end

  assign mem_address    = 32'(r_addr);
  assign mem_write_data = r_wdata;
  assign rsp_rdata      = r_rdata;

endmodule
